// File: rtl/dlx_pkg.sv
// Shared DLX constants for the instruction-fetch front end.
// The fetch queue takes its parameter defaults from here.
package dlx_pkg;

  localparam int DLX_DATA_WIDTH      = 32;
  localparam int DLX_INST_ADDR_WIDTH = 20;
  localparam logic [DLX_INST_ADDR_WIDTH-1:0] DLX_PC_INITIAL_ADDRESS = 20'h40000;
  localparam int DLX_PC_STEP         = 4;

  // All-zero word. Decode sees this word whenever the fetch queue has nothing to present.
  localparam logic [DLX_DATA_WIDTH-1:0] DLX_NOP = '0;

endpackage

// File: rtl/dlx_sync_fifo.sv
// Show-ahead synchronous FIFO with a flush input. A pop on an empty FIFO is ignored.
// A push and a pop in the same cycle on a full FIFO is legal.
module dlx_sync_fifo #(
  parameter int WIDTH = 52,
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage holds only data, so it is not reset. On a full FIFO with a simultaneous pop,
  // the write lands in the slot that is being vacated.
  always_ff @(posedge clk) begin
    if (do_push && !(rst || flush)) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/dlx_fetch_queue.sv
// DLX instruction-fetch front end. It issues pipelined, credit-limited memory requests and
// buffers in-order responses. On a redirect it discards stale in-flight responses.
module dlx_fetch_queue
  import dlx_pkg::*;
#(
  parameter int DATA_WIDTH      = DLX_DATA_WIDTH,
  parameter int INST_ADDR_WIDTH = DLX_INST_ADDR_WIDTH,
  parameter logic [INST_ADDR_WIDTH-1:0] PC_INITIAL_ADDRESS = DLX_PC_INITIAL_ADDRESS,
  parameter int PC_STEP         = DLX_PC_STEP,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic                       instr_rd_en,
  output logic [INST_ADDR_WIDTH-1:0] instr_addr,
  input  logic                       instr_ready,
  input  logic                       instr_valid,
  input  logic [DATA_WIDTH-1:0]      instruction,
  input  logic                       redirect_in,
  input  logic [INST_ADDR_WIDTH-1:0] redirect_pc_in,
  input  logic                       halt_in,
  input  logic                       id_ready_in,
  output logic                       if_valid_out,
  output logic [DATA_WIDTH-1:0]      instruction_out,
  output logic [INST_ADDR_WIDTH-1:0] pc_out,
  output logic [INST_ADDR_WIDTH-1:0] new_pc_out,
  output logic                       fetch_idle_out
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int EW = INST_ADDR_WIDTH + DATA_WIDTH;
  localparam logic [INST_ADDR_WIDTH-1:0] STEP = INST_ADDR_WIDTH'(PC_STEP);

  logic [INST_ADDR_WIDTH-1:0] fetch_pc;
  logic [INST_ADDR_WIDTH-1:0] resp_pc;
  logic [CW-1:0]              outstanding;
  logic [CW-1:0]              drop_cnt;
  logic [CW-1:0]              fifo_count;
  logic [CW:0]                credit_used;
  logic                       fifo_empty;
  logic [EW-1:0]              fifo_rdata;
  logic                       issue;
  logic                       resp;
  logic                       drop_resp;
  logic                       push;
  logic                       pop;

  // Every issued request reserves a FIFO slot until its entry is popped or dropped.
  // Because of this reservation, a write can never overflow the FIFO.
  assign credit_used = {1'b0, outstanding} + {1'b0, fifo_count};
  assign instr_rd_en = !rst && !halt_in && !redirect_in && (credit_used < (CW+1)'(FIFO_DEPTH));
  assign instr_addr  = fetch_pc;
  assign issue       = instr_rd_en && instr_ready;

  assign resp      = instr_valid && (outstanding != '0);
  assign drop_resp = resp && (drop_cnt != '0);
  assign push      = resp && !drop_resp && !redirect_in;
  assign pop       = if_valid_out && id_ready_in && !redirect_in;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= PC_INITIAL_ADDRESS;
      resp_pc     <= PC_INITIAL_ADDRESS;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      case ({issue, resp})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
      if (redirect_in) begin
        // Every request still in flight after this edge belongs to the old path.
        fetch_pc <= redirect_pc_in;
        resp_pc  <= redirect_pc_in;
        drop_cnt <= outstanding - CW'(resp);
      end else begin
        if (issue)     fetch_pc <= fetch_pc + STEP;
        if (push)      resp_pc  <= resp_pc + STEP;
        if (drop_resp) drop_cnt <= drop_cnt - 1'b1;
      end
    end
  end

  dlx_sync_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (redirect_in),
    .wdata ({resp_pc, instruction}),
    .rdata (fifo_rdata),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign if_valid_out    = !fifo_empty;
  assign pc_out          = if_valid_out ? fifo_rdata[EW-1:DATA_WIDTH] : '0;
  assign instruction_out = if_valid_out ? fifo_rdata[DATA_WIDTH-1:0] : DLX_NOP;
  assign new_pc_out      = pc_out + STEP;
  assign fetch_idle_out  = (outstanding == '0) && fifo_empty;

endmodule

// File: tb/tb_dlx_fetch_queue.sv
// Randomized bench for dlx_fetch_queue. An in-order memory model and a request-epoch
// reference queue predict every output cycle by cycle.
module tb_dlx_fetch_queue;

  localparam logic [19:0] PC_INIT = 20'h40000;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_rd_en;
  logic [19:0] instr_addr;
  logic        instr_ready;
  logic        instr_valid;
  logic [31:0] instruction;
  logic        redirect_in;
  logic [19:0] redirect_pc_in;
  logic        halt_in;
  logic        id_ready_in;
  logic        if_valid_out;
  logic [31:0] instruction_out;
  logic [19:0] pc_out;
  logic [19:0] new_pc_out;
  logic        fetch_idle_out;

  always #5 clk = ~clk;

  dlx_fetch_queue dut (
    .clk             (clk),
    .rst             (rst),
    .instr_rd_en     (instr_rd_en),
    .instr_addr      (instr_addr),
    .instr_ready     (instr_ready),
    .instr_valid     (instr_valid),
    .instruction     (instruction),
    .redirect_in     (redirect_in),
    .redirect_pc_in  (redirect_pc_in),
    .halt_in         (halt_in),
    .id_ready_in     (id_ready_in),
    .if_valid_out    (if_valid_out),
    .instruction_out (instruction_out),
    .pc_out          (pc_out),
    .new_pc_out      (new_pc_out),
    .fetch_idle_out  (fetch_idle_out)
  );

  typedef struct {
    logic [19:0] addr;
    int          epoch;
    int          due;
  } req_t;

  req_t        mem_q[$];
  logic [51:0] exp_q[$];
  logic [19:0] m_fetch_pc;
  int          epoch;
  int          cyc;
  int          checks;
  int          errors;

  int          k_rst_force;
  int          k_lat_min;
  int          k_lat_max;
  int          k_p_ready;
  int          k_p_id;
  int          k_p_halt;
  int          k_p_redir;
  int          k_p_rst;
  int          k_redir_at;
  int          k_use_fixed;
  logic [19:0] k_target;

  function automatic logic [31:0] mem_word(input logic [19:0] a);
    return {a, 12'h000} ^ {12'h000, a} ^ 32'h5A5A_C3C3;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", tag, cyc, got, exp);
    end
  endtask

  function automatic bit chance(input int pct);
    return $urandom_range(99, 0) < pct;
  endfunction

  task automatic set_knobs(input int lmin, input int lmax, input int pr, input int pid,
                           input int ph, input int pre, input int prst);
    k_lat_min = lmin; k_lat_max = lmax; k_p_ready = pr; k_p_id = pid;
    k_p_halt = ph; k_p_redir = pre; k_p_rst = prst;
    k_redir_at = -1; k_use_fixed = 0; k_rst_force = 0;
  endtask

  task automatic step(input int idx);
    bit          exp_rd;
    bit          exp_v;
    logic [51:0] head;
    logic [19:0] exp_pc;
    logic [19:0] exp_npc;
    req_t        r;

    rst         = (k_rst_force != 0) || chance(k_p_rst);
    halt_in     = chance(k_p_halt);
    instr_ready = chance(k_p_ready);
    id_ready_in = chance(k_p_id);
    redirect_in = !rst && ((idx == k_redir_at) || chance(k_p_redir));
    if (k_use_fixed != 0)
      redirect_pc_in = k_target;
    else if (chance(20))
      redirect_pc_in = 20'hFFFF8;
    else
      redirect_pc_in = 20'($urandom) & 20'hFFFFC;
    if (!rst && mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      instr_valid = 1'b1;
      instruction = mem_word(mem_q[0].addr);
    end else begin
      instr_valid = 1'b0;
      instruction = 32'($urandom);
    end

    #1;
    exp_rd = !rst && !halt_in && !redirect_in && (mem_q.size() + exp_q.size() < DEPTH);
    check_eq("instr_rd_en", 32'(instr_rd_en), 32'(exp_rd));
    if (!rst) begin
      exp_v   = exp_q.size() > 0;
      head    = exp_v ? exp_q[0] : 52'h0;
      exp_pc  = head[51:32];
      exp_npc = exp_pc + 20'd4;
      check_eq("if_valid_out", 32'(if_valid_out), 32'(exp_v));
      check_eq("pc_out", 32'(pc_out), 32'(exp_pc));
      check_eq("instruction_out", instruction_out, head[31:0]);
      check_eq("new_pc_out", 32'(new_pc_out), 32'(exp_npc));
      check_eq("instr_addr", 32'(instr_addr), 32'(m_fetch_pc));
      check_eq("fetch_idle_out", 32'(fetch_idle_out),
               32'(mem_q.size() == 0 && exp_q.size() == 0));
    end

    if (rst) begin
      mem_q.delete();
      exp_q.delete();
      m_fetch_pc = PC_INIT;
      epoch++;
    end else begin
      if (exp_q.size() > 0 && id_ready_in && !redirect_in) void'(exp_q.pop_front());
      if (instr_valid) begin
        r = mem_q.pop_front();
        if (!redirect_in && r.epoch == epoch) exp_q.push_back({r.addr, mem_word(r.addr)});
      end
      if (exp_rd && instr_ready) begin
        mem_q.push_back('{addr: m_fetch_pc, epoch: epoch,
                          due: cyc + int'($urandom_range(k_lat_max, k_lat_min))});
        m_fetch_pc = m_fetch_pc + 20'd4;
      end
      if (redirect_in) begin
        exp_q.delete();
        epoch++;
        m_fetch_pc = redirect_pc_in;
      end
    end

    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(i);
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0; epoch = 0;
    m_fetch_pc = PC_INIT;
    rst = 1'b1; instr_ready = 1'b0; instr_valid = 1'b0; instruction = '0;
    redirect_in = 1'b0; redirect_pc_in = '0; halt_in = 1'b0; id_ready_in = 1'b0;
    @(negedge clk);

    // Reset, then streaming with single-cycle memory.
    set_knobs(1, 1, 100, 100, 0, 0, 0);
    k_rst_force = 1;
    run(2);
    k_rst_force = 0;
    run(30);

    // Backpressure from decode fills the credit window, then releases.
    set_knobs(1, 1, 100, 0, 0, 0, 0);
    run(12);
    k_p_id = 100;
    run(12);

    // Three-cycle memory with a redirect while requests are in flight.
    set_knobs(3, 3, 100, 100, 0, 0, 0);
    k_redir_at = 5; k_use_fixed = 1; k_target = 20'h40100;
    run(20);

    // Halt with requests in flight, drain to idle.
    set_knobs(2, 2, 100, 100, 0, 0, 0);
    run(3);
    k_p_halt = 100;
    run(10);

    // Reset pulse mid-stream with a full FIFO.
    set_knobs(1, 1, 100, 0, 0, 0, 0);
    run(8);
    k_rst_force = 1;
    run(1);
    set_knobs(1, 1, 100, 100, 0, 0, 0);
    run(10);

    // Fully random traffic.
    set_knobs(1, 4, 70, 60, 10, 5, 1);
    run(2500);

    // Final drain.
    set_knobs(1, 4, 100, 100, 100, 0, 0);
    run(20);
    check_eq("final_idle", 32'(fetch_idle_out), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
